// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline encodings used by the MEM stage: access sizes, control bit
// positions, FSM states and the alignment rule.
package pipeline_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam int unsigned MEM_LOAD_BIT  = 1;
    localparam int unsigned MEM_STORE_BIT = 0;
    localparam int unsigned WB_WE_BIT     = 0;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } memState_e;

    // Size code 2'b11 behaves as a word access.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        unique case (size)
            LS_BYTE: bad = 1'b0;
            LS_HALF: bad = addrLo[0];
            default: bad = |addrLo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and the
// data memory (slave).
interface memory_stage_if #(
    parameter int unsigned ADDR_W = 12
);

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage: store byte enables and replicated write
// data, and load lane extraction with sign/zero extension.
module mem_lane_align
    import pipeline_pkg::*;
(
    input  logic [1:0]  stSize_i,
    input  logic [1:0]  stAddr_i,
    input  logic [31:0] stData_i,
    output logic [3:0]  stBe_o,
    output logic [31:0] stWdata_o,

    input  logic [1:0]  ldSize_i,
    input  logic [1:0]  ldAddr_i,
    input  logic        ldUnsigned_i,
    input  logic [31:0] ldRdata_i,
    output logic [31:0] ldData_o
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        stBe_o    = 4'b1111;
        stWdata_o = stData_i;
        unique case (stSize_i)
            LS_BYTE: begin
                stBe_o    = 4'b0001 << stAddr_i;
                stWdata_o = {4{stData_i[7:0]}};
            end
            LS_HALF: begin
                stBe_o    = stAddr_i[1] ? 4'b1100 : 4'b0011;
                stWdata_o = {2{stData_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign ldByte = ldRdata_i[{ldAddr_i, 3'b000} +: 8];
    assign ldHalf = ldAddr_i[1] ? ldRdata_i[31:16] : ldRdata_i[15:0];

    always_comb begin
        unique case (ldSize_i)
            LS_BYTE: ldData_o = {{24{~ldUnsigned_i & ldByte[7]}}, ldByte};
            LS_HALF: ldData_o = {{16{~ldUnsigned_i & ldHalf[15]}}, ldHalf};
            default: ldData_o = ldRdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: issues loads/stores over the dmem req/ack port, stalls the pipe while an
// access is outstanding, and registers the MEM/WB bundle. MEM_TIMEOUT_EN adds a wait abort.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [4:0]  inWB,
    input  logic [1:0]  inMEM,
    input  logic [1:0]  in_ls_size,
    input  logic        in_ls_unsigned,
    input  logic        inJL,
    input  logic [31:0] inNextInstructionAddress,
    input  logic [31:0] inALUResult,
    input  logic [31:0] inRegB,
    input  logic [4:0]  inRegF_wreg,
    input  logic        stop_debug,

    memory_stage_if.master dmem,

    output logic        stall_pipe,
    output logic [4:0]  outWB,
    output logic        outJL,
    output logic [31:0] outNextInstructionAddress,
    output logic [31:0] outALUResult,
    output logic [31:0] outMemData,
    output logic [4:0]  outRegF_wreg,
    output logic        err_misalign
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        err_timeout
`endif
);

    localparam logic [4:0] WbWeMask = 5'(1) << WB_WE_BIT;

    memState_e state;

    logic isLoad, isStore, memIllegal, memOp, misaligned, startAccess;

    logic [3:0]  stBe;
    logic [31:0] stWdata;
    logic [31:0] ldData;

    // Bundle captured when the access starts, retired when it completes.
    logic [4:0]  heldWB;
    logic        heldJL;
    logic [31:0] heldNia;
    logic [31:0] heldAlu;
    logic [4:0]  heldWreg;
    logic [1:0]  heldSize;
    logic        heldUnsigned;
    logic        heldLoad;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] waitCnt;
    logic            timeoutHit;
    assign timeoutHit = (waitCnt == CntW'(TIMEOUT_CYCLES - 1));
`endif

    assign isLoad      = inMEM[MEM_LOAD_BIT];
    assign isStore     = inMEM[MEM_STORE_BIT];
    assign memIllegal  = isLoad & isStore;
    assign memOp       = isLoad ^ isStore;
    assign misaligned  = memOp & isMisaligned(in_ls_size, inALUResult[1:0]);
    assign startAccess = (state == StIdle) & memOp & ~misaligned;
    assign stall_pipe  = (state == StWait) | startAccess;

    mem_lane_align uAlign (
        .stSize_i    (in_ls_size),
        .stAddr_i    (inALUResult[1:0]),
        .stData_i    (inRegB),
        .stBe_o      (stBe),
        .stWdata_o   (stWdata),
        .ldSize_i    (heldSize),
        .ldAddr_i    (dmem.dmem_addr[1:0]),
        .ldUnsigned_i(heldUnsigned),
        .ldRdata_i   (dmem.dmem_rdata),
        .ldData_o    (ldData)
    );

    always_ff @(negedge clk) begin
        if (!rst) begin
            state                     <= StIdle;
            dmem.dmem_req             <= 1'b0;
            dmem.dmem_we              <= 1'b0;
            dmem.dmem_addr            <= '0;
            dmem.dmem_be              <= '0;
            dmem.dmem_wdata           <= '0;
            outWB                     <= '0;
            outJL                     <= 1'b0;
            outNextInstructionAddress <= '0;
            outALUResult              <= '0;
            outMemData                <= '0;
            outRegF_wreg              <= '0;
            err_misalign              <= 1'b0;
            heldWB                    <= '0;
            heldJL                    <= 1'b0;
            heldNia                   <= '0;
            heldAlu                   <= '0;
            heldWreg                  <= '0;
            heldSize                  <= '0;
            heldUnsigned              <= 1'b0;
            heldLoad                  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            waitCnt                   <= '0;
            err_timeout               <= 1'b0;
`endif
        end else if (!stop_debug) begin
            err_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (startAccess) begin
                        state                     <= StWait;
                        dmem.dmem_req             <= 1'b1;
                        dmem.dmem_we              <= isStore;
                        dmem.dmem_addr            <= inALUResult[ADDR_W-1:0];
                        dmem.dmem_be              <= isStore ? stBe : 4'b1111;
                        dmem.dmem_wdata           <= isStore ? stWdata : '0;
                        heldWB                    <= inWB;
                        heldJL                    <= inJL;
                        heldNia                   <= inNextInstructionAddress;
                        heldAlu                   <= inALUResult;
                        heldWreg                  <= inRegF_wreg;
                        heldSize                  <= in_ls_size;
                        heldUnsigned              <= in_ls_unsigned;
                        heldLoad                  <= isLoad;
                        // Bubble into MEM/WB while the access is outstanding.
                        outWB                     <= '0;
                        outJL                     <= 1'b0;
                        outNextInstructionAddress <= '0;
                        outALUResult              <= '0;
                        outMemData                <= '0;
                        outRegF_wreg              <= '0;
`ifdef MEM_TIMEOUT_EN
                        waitCnt                   <= '0;
`endif
                    end else begin
                        outWB <= (memIllegal | misaligned) ? (inWB & ~WbWeMask) : inWB;
                        outJL                     <= inJL;
                        outNextInstructionAddress <= inNextInstructionAddress;
                        outALUResult              <= inALUResult;
                        outMemData                <= '0;
                        outRegF_wreg              <= inRegF_wreg;
                        err_misalign              <= memIllegal | misaligned;
                    end
                end
                StWait: begin
                    if (dmem.dmem_ack) begin
                        state                     <= StIdle;
                        dmem.dmem_req             <= 1'b0;
                        outWB                     <= heldWB;
                        outJL                     <= heldJL;
                        outNextInstructionAddress <= heldNia;
                        outALUResult              <= heldAlu;
                        outMemData                <= heldLoad ? ldData : '0;
                        outRegF_wreg              <= heldWreg;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timeoutHit) begin
                        state                     <= StIdle;
                        dmem.dmem_req             <= 1'b0;
                        outWB                     <= heldWB & ~WbWeMask;
                        outJL                     <= heldJL;
                        outNextInstructionAddress <= heldNia;
                        outALUResult              <= heldAlu;
                        outMemData                <= '0;
                        outRegF_wreg              <= heldWreg;
                        err_timeout               <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + CntW'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; state changes on negedge, so inputs are
// driven and outputs sampled 1 time unit after each falling edge.
module tb_memory_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic [4:0]  inWB;
    logic [1:0]  inMEM;
    logic [1:0]  in_ls_size;
    logic        in_ls_unsigned;
    logic        inJL;
    logic [31:0] inNextInstructionAddress;
    logic [31:0] inALUResult;
    logic [31:0] inRegB;
    logic [4:0]  inRegF_wreg;
    logic        stop_debug;
    logic        stall_pipe;
    logic [4:0]  outWB;
    logic        outJL;
    logic [31:0] outNextInstructionAddress;
    logic [31:0] outALUResult;
    logic [31:0] outMemData;
    logic [4:0]  outRegF_wreg;
    logic        err_misalign;
`ifdef MEM_TIMEOUT_EN
    logic        err_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    memory_stage_if #(.ADDR_W(12)) bus ();

    memory_stage #(.ADDR_W(12)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .inWB                     (inWB),
        .inMEM                    (inMEM),
        .in_ls_size               (in_ls_size),
        .in_ls_unsigned           (in_ls_unsigned),
        .inJL                     (inJL),
        .inNextInstructionAddress (inNextInstructionAddress),
        .inALUResult              (inALUResult),
        .inRegB                   (inRegB),
        .inRegF_wreg              (inRegF_wreg),
        .stop_debug               (stop_debug),
        .dmem                     (bus),
        .stall_pipe               (stall_pipe),
        .outWB                    (outWB),
        .outJL                    (outJL),
        .outNextInstructionAddress(outNextInstructionAddress),
        .outALUResult             (outALUResult),
        .outMemData               (outMemData),
        .outRegF_wreg             (outRegF_wreg),
        .err_misalign             (err_misalign)
`ifdef MEM_TIMEOUT_EN
        ,
        .err_timeout              (err_timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic setBundle(input logic [1:0] mem, input logic [1:0] size, input logic uns,
                             input logic [31:0] alu, input logic [31:0] regB,
                             input logic [4:0] wb, input logic [4:0] wreg);
        inMEM          = mem;
        in_ls_size     = size;
        in_ls_unsigned = uns;
        inALUResult    = alu;
        inRegB         = regB;
        inWB           = wb;
        inRegF_wreg    = wreg;
    endtask

    task automatic nop();
        setBundle(2'b00, LS_WORD, 1'b0, 32'h0, 32'h0, 5'b0, 5'd0);
    endtask

    initial begin
        bus.dmem_ack             = 1'b0;
        bus.dmem_rdata           = '0;
        stop_debug               = 1'b0;
        inJL                     = 1'b0;
        inNextInstructionAddress = '0;
        nop();

        // Reset state
        tick();
        tick();
        check("rst_outWB", 32'(outWB), 32'h0);
        check("rst_req", 32'(bus.dmem_req), 32'h0);
        check("rst_stall", 32'(stall_pipe), 32'h0);
        check("rst_alu", outALUResult, 32'h0);
        check("rst_err", 32'(err_misalign), 32'h0);
        rst = 1'b1;

        // Non-memory op: one-edge latency, no stall
        setBundle(2'b00, LS_WORD, 1'b0, 32'h1234, 32'h0, 5'b00001, 5'd5);
        inJL = 1'b1;
        inNextInstructionAddress = 32'h400;
        #1 check("alu_stall_pre", 32'(stall_pipe), 32'h0);
        tick();
        check("alu_result", outALUResult, 32'h1234);
        check("alu_wreg", 32'(outRegF_wreg), 32'd5);
        check("alu_wb", 32'(outWB), 32'h1);
        check("alu_jl", 32'(outJL), 32'h1);
        check("alu_nia", outNextInstructionAddress, 32'h400);
        check("alu_memdata", outMemData, 32'h0);
        check("alu_stall_post", 32'(stall_pipe), 32'h0);
        inJL = 1'b0;
        inNextInstructionAddress = '0;

        // Signed byte load at 0x003, ack on the third WAIT edge: four stalled cycles
        setBundle(2'b10, LS_BYTE, 1'b0, 32'h003, 32'h0, 5'b00001, 5'd7);
        #1 check("lb_stall_c1", 32'(stall_pipe), 32'h1);
        tick();
        check("lb_req", 32'(bus.dmem_req), 32'h1);
        check("lb_we", 32'(bus.dmem_we), 32'h0);
        check("lb_addr", 32'(bus.dmem_addr), 32'h003);
        check("lb_be", 32'(bus.dmem_be), 32'hF);
        check("lb_bubble_wb", 32'(outWB), 32'h0);
        check("lb_bubble_wreg", 32'(outRegF_wreg), 32'h0);
        check("lb_stall_c2", 32'(stall_pipe), 32'h1);
        tick();
        check("lb_stall_c3", 32'(stall_pipe), 32'h1);
        tick();
        check("lb_stall_c4", 32'(stall_pipe), 32'h1);
        check("lb_req_held", 32'(bus.dmem_req), 32'h1);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h80AABBCC;
        tick();
        bus.dmem_ack = 1'b0;
        nop();
        #1;
        check("lb_req_done", 32'(bus.dmem_req), 32'h0);
        check("lb_stall_done", 32'(stall_pipe), 32'h0);
        check("lb_data", outMemData, 32'hFFFFFF80);
        check("lb_wb", 32'(outWB), 32'h1);
        check("lb_wreg", 32'(outRegF_wreg), 32'd7);

        // Unsigned byte load, minimum two-edge latency
        setBundle(2'b10, LS_BYTE, 1'b1, 32'h003, 32'h0, 5'b00001, 5'd8);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h80AABBCC;
        tick();
        bus.dmem_ack = 1'b0;
        nop();
        check("lbu_data", outMemData, 32'h00000080);
        check("lbu_wreg", 32'(outRegF_wreg), 32'd8);

        // Signed half load from the upper half
        setBundle(2'b10, LS_HALF, 1'b0, 32'h002, 32'h0, 5'b00001, 5'd9);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hF00D1234;
        tick();
        bus.dmem_ack = 1'b0;
        nop();
        check("lh_data", outMemData, 32'hFFFFF00D);

        // Half store at 0x006
        setBundle(2'b01, LS_HALF, 1'b0, 32'h006, 32'h0000BEEF, 5'b10000, 5'd0);
        tick();
        check("sh_req", 32'(bus.dmem_req), 32'h1);
        check("sh_we", 32'(bus.dmem_we), 32'h1);
        check("sh_addr", 32'(bus.dmem_addr), 32'h006);
        check("sh_be", 32'(bus.dmem_be), 32'hC);
        check("sh_wdata", bus.dmem_wdata, 32'hBEEFBEEF);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h0000DEAD;
        tick();
        bus.dmem_ack = 1'b0;
        nop();
        check("sh_wb", 32'(outWB), 32'h10);
        check("sh_memdata", outMemData, 32'h0);

        // Byte store at lane 1
        setBundle(2'b01, LS_BYTE, 1'b0, 32'h001, 32'h12345678, 5'b00000, 5'd0);
        tick();
        check("sb_be", 32'(bus.dmem_be), 32'h2);
        check("sb_wdata", bus.dmem_wdata, 32'h78787878);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        nop();

        // Misaligned word load: no request, error pulse, writeback suppressed
        setBundle(2'b10, LS_WORD, 1'b0, 32'h102, 32'h0, 5'b00001, 5'd9);
        #1 check("mis_stall", 32'(stall_pipe), 32'h0);
        tick();
        check("mis_req", 32'(bus.dmem_req), 32'h0);
        check("mis_err", 32'(err_misalign), 32'h1);
        check("mis_wb", 32'(outWB), 32'h0);
        check("mis_memdata", outMemData, 32'h0);
        check("mis_wreg", 32'(outRegF_wreg), 32'd9);
        nop();
        tick();
        check("mis_err_pulse", 32'(err_misalign), 32'h0);

        // Illegal MEM control 2'b11
        setBundle(2'b11, LS_WORD, 1'b0, 32'h010, 32'h0, 5'b00011, 5'd3);
        tick();
        check("ill_err", 32'(err_misalign), 32'h1);
        check("ill_wb", 32'(outWB), 32'h2);
        check("ill_req", 32'(bus.dmem_req), 32'h0);

        // Stray ack in IDLE is ignored
        setBundle(2'b00, LS_WORD, 1'b0, 32'h55, 32'h0, 5'b00001, 5'd4);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFFFFFF;
        tick();
        bus.dmem_ack = 1'b0;
        check("idle_ack_req", 32'(bus.dmem_req), 32'h0);
        check("idle_ack_memdata", outMemData, 32'h0);
        check("idle_ack_alu", outALUResult, 32'h55);

        // Reset during WAIT abandons the access
        setBundle(2'b10, LS_WORD, 1'b0, 32'h010, 32'h0, 5'b00001, 5'd6);
        tick();
        check("rw_req_pre", 32'(bus.dmem_req), 32'h1);
        rst = 1'b0;
        tick();
        check("rw_req", 32'(bus.dmem_req), 32'h0);
        check("rw_wb", 32'(outWB), 32'h0);
        nop();
        #1 check("rw_stall", 32'(stall_pipe), 32'h0);
        rst = 1'b1;
        setBundle(2'b10, LS_WORD, 1'b0, 32'h020, 32'h0, 5'b00001, 5'd10);
        tick();
        check("rw_new_req", 32'(bus.dmem_req), 32'h1);
        check("rw_new_addr", 32'(bus.dmem_addr), 32'h020);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hCAFEF00D;
        tick();
        bus.dmem_ack = 1'b0;
        nop();
        check("rw_new_data", outMemData, 32'hCAFEF00D);
        check("rw_new_wreg", 32'(outRegF_wreg), 32'd10);

        // stop_debug in WAIT: the ack is not consumed
        setBundle(2'b10, LS_WORD, 1'b0, 32'h000, 32'h0, 5'b00001, 5'd11);
        tick();
        stop_debug     = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h11223344;
        tick();
        check("dbg_req", 32'(bus.dmem_req), 32'h1);
        check("dbg_wb", 32'(outWB), 32'h0);
        check("dbg_memdata", outMemData, 32'h0);
        check("dbg_stall", 32'(stall_pipe), 32'h1);
        bus.dmem_ack = 1'b0;
        stop_debug   = 1'b0;
        tick();
        check("dbg_still_wait", 32'(bus.dmem_req), 32'h1);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        nop();
        check("dbg_data", outMemData, 32'h11223344);
        check("dbg_wreg", 32'(outRegF_wreg), 32'd11);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort on the sixteenth WAIT edge
        setBundle(2'b10, LS_WORD, 1'b0, 32'h040, 32'h0, 5'b00001, 5'd12);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("to_req_pre", 32'(bus.dmem_req), 32'h1);
        check("to_err_pre", 32'(err_timeout), 32'h0);
        tick();
        nop();
        check("to_req", 32'(bus.dmem_req), 32'h0);
        check("to_err", 32'(err_timeout), 32'h1);
        check("to_wb", 32'(outWB), 32'h0);
        check("to_wreg", 32'(outRegF_wreg), 32'd12);
        tick();
        check("to_err_pulse", 32'(err_timeout), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of execute.
- Consumes the EX/MEM bundle: WB control, MEM control, ALU result, store data, destination register, link flag and PC+4.
- Performs byte, half and word loads and stores over a req/ack data-memory port, stalling the pipeline while an access is outstanding.
- Registers the MEM/WB bundle.

Parameters:
ADDR_W, 12, byte-address width driven on dmem_addr (low ADDR_W bits of the ALU result)
TIMEOUT_CYCLES, 16, wait cycles before abort (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on negedge clk, matching pipeline timing
rst  in  1  reset
inWB  in  5  WB control; inWB[0] = regfile write enable
inMEM  in  2  [1] = load, [0] = store; 2'b11 is illegal
in_ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
in_ls_unsigned  in  1  zero-extend loads when 1
inJL  in  1  jump-and-link flag, passed through
inNextInstructionAddress  in  32  PC+4, passed through
inALUResult  in  32  effective address, or result for non-memory ops
inRegB  in  32  store data
inRegF_wreg  in  5  destination register
stop_debug  in  1  freeze: no state change while 1
dmem_req  out  1  registered access request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  byte address
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-aligned store data
dmem_ack  in  1  one-cycle completion strobe
dmem_rdata  in  32  read word, valid with ack
stall_pipe  out  1  upstream must hold its EX/MEM outputs while 1
outWB  out  5  registered WB control
outJL  out  1  registered link flag
outNextInstructionAddress  out  32  registered PC+4
outALUResult  out  32  registered ALU result
outMemData  out  32  registered extended load data
outRegF_wreg  out  5  registered destination register
err_misalign  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset is synchronous and active-low: when rst==0 at a negedge, all registered outputs go to 0 and the FSM goes to IDLE.
  - Reset during WAIT abandons the access; dmem_req drops on that edge.
- FSM states:
  - IDLE: accepts a bundle each cycle.
  - WAIT: dmem_req=1, attributes held stable until ack.
- Non-memory op (inMEM==00) in IDLE: MEM/WB register loads the bundle on the next edge (1-cycle latency); outMemData=0.
- Memory op in IDLE, aligned:
  - stall_pipe=1 combinationally.
  - On the edge: go to WAIT, set dmem_req=1 and latch we, addr, be and wdata.
  - MEM/WB register loads a bubble (outWB=0, outRegF_wreg=0).
- WAIT:
  - stall_pipe=1.
  - When dmem_ack=1 at the edge: dmem_req goes 0, state goes IDLE, and MEM/WB loads the held bundle.
  - For loads, outMemData is the extracted and extended value.
  - stall_pipe falls once the FSM is back in IDLE. Minimum memory-op latency is 2 edges.
- Alignment: a half access needs addr[0]==0; a word access needs addr[1:0]==0.
  - A misaligned access issues no request, pulses err_misalign and completes in 1 cycle.
  - It forces outWB[0]=0 and outMemData=0.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{RegB[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{RegB[15:0]}}.
  - word: be = 1111.
- Loads: dmem_be = 1111; select the byte/half lane by addr[1:0], then sign- or zero-extend to 32 bits.
- inMEM==11 is treated as no-op plus err_misalign pulse; writeback is suppressed.
- dmem_ack while in IDLE is ignored.
- stop_debug=1 overrides everything except reset: FSM, outputs and dmem_req are all held.
- Store ops still forward the WB bundle, with outWB as given by the decoder.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A saturating counter runs in WAIT and is cleared when entering WAIT.
  - On reaching TIMEOUT_CYCLES without ack, the access aborts: dmem_req goes 0, state goes IDLE.
  - The bundle is retired with outWB[0]=0, and an extra output err_timeout pulses for 1 cycle.
- Undefined: no counter and no err_timeout port; WAIT lasts until ack indefinitely.

Decomposition:
- Shared package (pipeline_pkg): size encodings (LS_BYTE, LS_HALF, LS_WORD), MEM control bit indices, WB write-enable bit index, FSM state constants.
- One sub-module, mem_lane_align: combinational store be/wdata generation and load extract/extend.
- The FSM and MEM/WB register stay in memory_stage.

Test Plan:
- ALU op: inMEM=00, inALUResult=0x1234, inRegF_wreg=5 → after 1 edge outALUResult=0x1234, outRegF_wreg=5, stall_pipe never 1.
- Signed byte load: addr 0x003, ack after 3 cycles with rdata=0x80AABBCC → stall 4 cycles, outMemData=0xFFFFFF80; same with unsigned=1 → 0x00000080.
- Half store: addr 0x006, RegB=0x0000BEEF → dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1.
- Misaligned word: addr 0x102 → no dmem_req, err_misalign 1 cycle, outWB[0]=0.
- Reset mid-access: rst=0 while in WAIT → next edge dmem_req=0, all outputs 0, state IDLE, and a new access issues normally after release.
- stop_debug asserted in WAIT with ack pulsed → ack not consumed, outputs frozen; MEM_TIMEOUT_EN build with no ack → abort after 16 cycles, err_timeout pulse.
